skipjack_cmd_ctrl: RTL

Byte-command controller between the UART AXI-Stream byte ports and the `skipjack_iterative` core. It replaces the fixed key constant and the 8↔64 width adapters. It parses a simple host protocol, loads an 80-bit key at run time, and sequences one 64-bit block through the cipher per command. It returns the 8 result bytes to the UART transmitter.

---
 rtl/skipjack_cmd_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/skipjack_cmd_ctrl.sv
// skipjack_cmd_ctrl: byte-command front end for the iterative Skipjack core.
// Parses 'K' (10-byte key load) and 'E' (8-byte block encrypt) commands from
// the UART RX byte stream. It drives one block through the cipher and returns
// the 8 result bytes, most significant byte first, on the UART TX byte stream.
// Optional feature macro: SKIPJACK_CTRL_STATUS_EN adds a STATUS state that
// sends ACK (0x06) after a key load, and NAK (0x15) after an unknown command
// or a receive timeout.
module skipjack_cmd_ctrl #(
  parameter logic [79:0] KEY_RESET      = 80'h00998877665544332211,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_axis_rx_tdata,
  input  logic        s_axis_rx_tvalid,
  output logic        s_axis_rx_tready,
  output logic [7:0]  m_axis_tx_tdata,
  output logic        m_axis_tx_tvalid,
  input  logic        m_axis_tx_tready,
  output logic [0:79] key,
  output logic [63:0] m_axis_cph_tdata,
  output logic        m_axis_cph_tvalid,
  input  logic        m_axis_cph_tready,
  input  logic [63:0] s_axis_cph_tdata,
  input  logic        s_axis_cph_tvalid,
  output logic        s_axis_cph_tready,
  output logic        busy
);

  localparam logic [7:0] CMD_KEY = 8'h4B;
  localparam logic [7:0] CMD_ENC = 8'h45;

  localparam bit          TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

`ifdef SKIPJACK_CTRL_STATUS_EN
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  typedef enum logic [2:0] {
    IDLE, KEY_RX, BLK_RX, CPH_SEND, CPH_WAIT, TX_RESULT, STATUS
  } state_t;

  // Terminal states of a key load and of an aborted/unknown command.
  localparam state_t AFTER_KEY = STATUS;
  localparam state_t AFTER_ERR = STATUS;
`else
  typedef enum logic [2:0] {
    IDLE, KEY_RX, BLK_RX, CPH_SEND, CPH_WAIT, TX_RESULT
  } state_t;

  localparam state_t AFTER_KEY = IDLE;
  localparam state_t AFTER_ERR = IDLE;
`endif

  state_t        state, state_n;
  logic [3:0]    cnt;
  logic [TW-1:0] timer;
  logic [0:71]   shadow;
  logic [63:0]   blk;
  logic [63:0]   res;
`ifdef SKIPJACK_CTRL_STATUS_EN
  logic [7:0]    status;
`endif

  logic in_rx;
  logic rx_hs, tx_hs, cph_out_hs, cph_in_hs;
  logic timeout;
  logic cmd_known;

  assign in_rx      = (state == KEY_RX) || (state == BLK_RX);
  assign rx_hs      = s_axis_rx_tvalid & s_axis_rx_tready;
  assign tx_hs      = m_axis_tx_tvalid & m_axis_tx_tready;
  assign cph_out_hs = m_axis_cph_tvalid & m_axis_cph_tready;
  assign cph_in_hs  = s_axis_cph_tvalid & s_axis_cph_tready;
  assign timeout    = TO_EN && in_rx && !rx_hs && (timer == TO_LAST);
  assign cmd_known  = (s_axis_rx_tdata == CMD_KEY) || (s_axis_rx_tdata == CMD_ENC);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic and stream control outputs decoded from the state.
  always_comb begin
    state_n           = state;
    s_axis_rx_tready  = 1'b0;
    m_axis_tx_tvalid  = 1'b0;
    m_axis_tx_tdata   = res[63:56];
    m_axis_cph_tvalid = 1'b0;
    s_axis_cph_tready = 1'b0;
    busy              = (state != IDLE);
    m_axis_cph_tdata  = blk;

    unique case (state)
      IDLE: begin
        s_axis_rx_tready = !rst;
        if (rx_hs) begin
          if (s_axis_rx_tdata == CMD_KEY)      state_n = KEY_RX;
          else if (s_axis_rx_tdata == CMD_ENC) state_n = BLK_RX;
          else                                 state_n = AFTER_ERR;
        end
      end
      KEY_RX: begin
        s_axis_rx_tready = !rst;
        if (rx_hs && cnt == 4'd9) state_n = AFTER_KEY;
        else if (timeout)         state_n = AFTER_ERR;
      end
      BLK_RX: begin
        s_axis_rx_tready = !rst;
        if (rx_hs && cnt == 4'd7) state_n = CPH_SEND;
        else if (timeout)         state_n = AFTER_ERR;
      end
      CPH_SEND: begin
        m_axis_cph_tvalid = 1'b1;
        if (cph_out_hs) state_n = CPH_WAIT;
      end
      CPH_WAIT: begin
        s_axis_cph_tready = 1'b1;
        if (cph_in_hs) state_n = TX_RESULT;
      end
      TX_RESULT: begin
        m_axis_tx_tvalid = 1'b1;
        if (tx_hs && cnt == 4'd7) state_n = IDLE;
      end
`ifdef SKIPJACK_CTRL_STATUS_EN
      STATUS: begin
        m_axis_tx_tvalid = 1'b1;
        m_axis_tx_tdata  = status;
        if (tx_hs) state_n = IDLE;
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // Datapath: byte shifting, key commit, result capture, counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      key    <= KEY_RESET;
      shadow <= '0;
      blk    <= '0;
      res    <= '0;
      cnt    <= '0;
      timer  <= '0;
`ifdef SKIPJACK_CTRL_STATUS_EN
      status <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          cnt   <= '0;
          timer <= '0;
`ifdef SKIPJACK_CTRL_STATUS_EN
          if (rx_hs && !cmd_known) status <= NAK;
`endif
        end
        KEY_RX: begin
          if (rx_hs) begin
            // Only the first nine bytes are held; the tenth goes straight
            // into the key together with them so the update is atomic.
            shadow <= {shadow[8:71], s_axis_rx_tdata};
            cnt    <= cnt + 4'd1;
            timer  <= '0;
            if (cnt == 4'd9) begin
              key <= {shadow, s_axis_rx_tdata};
`ifdef SKIPJACK_CTRL_STATUS_EN
              status <= ACK;
`endif
            end
          end else begin
            timer <= timer + TW'(1);
`ifdef SKIPJACK_CTRL_STATUS_EN
            if (timeout) status <= NAK;
`endif
          end
        end
        BLK_RX: begin
          if (rx_hs) begin
            blk   <= {blk[55:0], s_axis_rx_tdata};
            cnt   <= cnt + 4'd1;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
`ifdef SKIPJACK_CTRL_STATUS_EN
            if (timeout) status <= NAK;
`endif
          end
        end
        CPH_WAIT: begin
          if (cph_in_hs) begin
            res <= s_axis_cph_tdata;
            cnt <= '0;
          end
        end
        TX_RESULT: begin
          if (tx_hs) begin
            res <= {res[55:0], 8'h00};
            cnt <= cnt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
